// File: rtl/slot_pkg.sv
// rtl/slot_pkg.sv - shared FSM encodings and default reel geometry for the slot engine
package slot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SPIN = 2'd1;
  localparam state_t ST_STOP = 2'd2;
  localparam state_t ST_SHOW = 2'd3;

  localparam int NUM_SYMS_DEF = 5;
  localparam int SYM_W_DEF    = 3;

endpackage

// File: rtl/slot_reel_bank_if.sv
// rtl/slot_reel_bank_if.sv - button/strobe inputs and reel display outputs of the slot engine
interface slot_reel_bank_if #(
  parameter int NUM_REELS = 3,
  parameter int SYM_W     = slot_pkg::SYM_W_DEF
);
  logic                       btn;
  logic                       step_en;
  logic [NUM_REELS*SYM_W-1:0] slot_pic;
  logic [NUM_REELS-1:0]       reel_spinning;
  logic                       done;
  logic                       win;

  modport master (output btn, step_en, input slot_pic, reel_spinning, done, win);
  modport slave  (input btn, step_en, output slot_pic, reel_spinning, done, win);
endinterface

// File: rtl/slot_reel_bank_reel.sv
// rtl/slot_reel_bank_reel.sv - one reel: down-counting symbol with a per-reel rate prescaler
module slot_reel #(
  parameter int NUM_SYMS = slot_pkg::NUM_SYMS_DEF,
  parameter int SYM_W    = slot_pkg::SYM_W_DEF,
  parameter int REEL_IDX = 0
) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             step_en_i,
  input  logic             freeze_i,
  input  logic             clr_i,
  output logic [SYM_W-1:0] value_o
);
  localparam int PSC_W = (REEL_IDX > 0) ? $clog2(REEL_IDX + 1) : 1;

  logic [SYM_W-1:0] value_q, value_d;
  logic [PSC_W-1:0] psc_q, psc_d;

  always_comb begin
    value_d = value_q;
    psc_d   = psc_q;
    if (clr_i) begin
      psc_d = '0;
    end else if (step_en_i && !freeze_i) begin
      // reel REEL_IDX advances once every REEL_IDX+1 strobes
      if (psc_q == PSC_W'(REEL_IDX)) begin
        psc_d   = '0;
        value_d = (value_q == '0) ? SYM_W'(NUM_SYMS - 1) : value_q - SYM_W'(1);
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrb) begin
      value_q <= SYM_W'(NUM_SYMS - 1);
      psc_q   <= '0;
    end else begin
      value_q <= value_d;
      psc_q   <= psc_d;
    end
  end

  assign value_o = value_q;
endmodule

// File: rtl/slot_reel_bank.sv
// rtl/slot_reel_bank.sv - multi-reel slot engine: spin FSM, staggered stop and win detect
module slot_reel_bank
  import slot_pkg::*;
#(
  parameter int NUM_REELS  = 3,
  parameter int NUM_SYMS   = NUM_SYMS_DEF,
  parameter int SYM_W      = SYM_W_DEF,
  parameter int STOP_DELAY = 2
) (
  input  logic               clk,
  input  logic               clrb,
  slot_reel_bank_if.slave    bus
);
  localparam int PTR_W = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
  localparam int CNT_W = $clog2(STOP_DELAY + 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [NUM_REELS-1:0]       spin_q, spin_d, freeze_now;
  logic                       done_q, done_d, win_q, win_d;
  logic                       start, all_eq, stop_hit, last_reel;
  logic [NUM_REELS*SYM_W-1:0] pic;

  assign stop_hit  = bus.step_en && (cnt_q == CNT_W'(STOP_DELAY - 1));
  assign last_reel = (ptr_q == PTR_W'(NUM_REELS - 1));

  always_ff @(posedge clk) begin
    if (!clrb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      spin_q  <= '0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      spin_q  <= spin_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_SHOW: if (!bus.btn) state_d = ST_SPIN;
      ST_SPIN:          if (bus.btn) state_d = ST_STOP;
      ST_STOP:          if (stop_hit && last_reel) state_d = ST_SHOW;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    spin_d     = spin_q;
    freeze_now = '0;
    done_d     = done_q;
    win_d      = win_q;
    case (state_q)
      ST_IDLE, ST_SHOW: begin
        if (!bus.btn) begin
          start  = 1'b1;
          spin_d = '1;
          done_d = 1'b0;
          win_d  = 1'b0;
        end else if (state_q == ST_SHOW) begin
          done_d = 1'b1;
          win_d  = all_eq;
        end
      end
      ST_SPIN: begin
        if (bus.btn) begin
          cnt_d = '0;
          ptr_d = '0;
        end
      end
      ST_STOP: begin
        if (stop_hit) begin
          for (int i = 0; i < NUM_REELS; i++) begin
            if (ptr_q == PTR_W'(i)) begin
              freeze_now[i] = 1'b1;
              spin_d[i]     = 1'b0;
            end
          end
          cnt_d = '0;
          ptr_d = ptr_q + PTR_W'(1);
        end else if (bus.step_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // the reel being frozen this cycle must not also take its step
  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    slot_reel #(
      .NUM_SYMS (NUM_SYMS),
      .SYM_W    (SYM_W),
      .REEL_IDX (g)
    ) u_reel (
      .clk       (clk),
      .clrb      (clrb),
      .step_en_i (bus.step_en),
      .freeze_i  (~spin_q[g] | freeze_now[g]),
      .clr_i     (start),
      .value_o   (pic[g*SYM_W +: SYM_W])
    );
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (pic[i*SYM_W +: SYM_W] != pic[SYM_W-1:0]) all_eq = 1'b0;
    end
  end

  assign bus.slot_pic      = pic;
  assign bus.reel_spinning = spin_q;
  assign bus.done          = done_q;
  assign bus.win           = win_q;
endmodule
